message_schedule: RTL and testbench

SHA-256 message-schedule stage, directly upstream of the round logic. It accepts one 512-bit block as sixteen 32-bit words over a valid/ready interface. It then streams the 64 per-round pairs (Wi, Ki) with a round index to the compression datapath, one pair per advance. Wi for rounds 16..63 comes from a 16-word sliding window; Ki comes from an internal 64-entry constant ROM.

---
 rtl/message_schedule.sv | 121 ++++++++++++
 tb/tb_message_schedule.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/message_schedule.sv
// SHA-256 message schedule: loads a 16-word block, then streams (Wi, Ki, round) for 64 rounds.
// Optional build macro SCHED_BYTESWAP_EN byte-reverses each word as it is loaded.
module message_schedule (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic        in_word_valid,
  input  logic [31:0] in_word,
  output logic        out_word_ready,
  input  logic        in_advance,
  output logic        out_valid,
  output logic [31:0] out_Wi,
  output logic [31:0] out_Ki,
  output logic [5:0]  out_round,
  output logic        out_done
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned WIN_N  = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned RND_W  = 6;
  localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(63);
  localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(15);

  localparam logic [WORD_W-1:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic {ST_LOAD, ST_RUN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   load_cnt_q, load_cnt_d;
  logic [RND_W-1:0]   round_q, round_d;
  logic [WORD_W-1:0]  window_q [WIN_N];
  logic [WORD_W-1:0]  window_d [WIN_N];
  logic               done_q, done_d;
  logic [WORD_W-1:0]  load_word;
  logic [WORD_W-1:0]  w_new;

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

`ifdef SCHED_BYTESWAP_EN
  assign load_word = {in_word[7:0], in_word[15:8], in_word[23:16], in_word[31:24]};
`else
  assign load_word = in_word;
`endif

  // Next schedule word from the sliding window (mod 2^32 by truncation)
  assign w_new = sig1(window_q[14]) + window_q[9] + sig0(window_q[1]) + window_q[0];

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    round_d    = round_q;
    window_d   = window_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        if (in_word_valid) begin
          for (int i = 0; i < WIN_N - 1; i++) window_d[i] = window_q[i+1];
          window_d[WIN_N-1] = load_word;
          load_cnt_d        = load_cnt_q + CNT_W'(1);
          if (load_cnt_q == LAST_WORD) begin
            round_d = '0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (in_advance) begin
          for (int i = 0; i < WIN_N - 1; i++) window_d[i] = window_q[i+1];
          window_d[WIN_N-1] = w_new;
          if (round_q == LAST_ROUND) begin
            round_d = '0;
            done_d  = 1'b1;
            state_d = ST_LOAD;
          end else begin
            round_d = round_q + RND_W'(1);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q    <= ST_LOAD;
      load_cnt_q <= '0;
      round_q    <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < WIN_N; i++) window_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      round_q    <= round_d;
      done_q     <= done_d;
      window_q   <= window_d;
    end
  end

  assign out_word_ready = (state_q == ST_LOAD);
  assign out_valid      = (state_q == ST_RUN);
  assign out_Wi         = window_q[0];
  assign out_Ki         = K_ROM[round_q];
  assign out_round      = round_q;
  assign out_done       = done_q;

endmodule

// File: tb/tb_message_schedule.sv
// Self-checking bench for message_schedule against a full-array SHA-256 schedule model.
module tb_message_schedule;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_word_valid = 1'b0;
  logic [31:0] in_word = '0;
  logic        in_advance = 1'b0;
  logic        out_word_ready, out_valid, out_done;
  logic [31:0] out_Wi, out_Ki;
  logic [5:0]  out_round;

  message_schedule dut (
    .in_clk(clk), .in_rst_n(rst_n), .in_word_valid(in_word_valid), .in_word(in_word),
    .out_word_ready(out_word_ready), .in_advance(in_advance), .out_valid(out_valid),
    .out_Wi(out_Wi), .out_Ki(out_Ki), .out_round(out_round), .out_done(out_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef logic [31:0] blk_t [16];
  typedef logic [31:0] sched_t [64];

  typedef struct {
    int          round;
    logic [31:0] wi;
    logic [31:0] ki;
    bit          chk_wi;
  } vec_t;

  vec_t vtab [5];

  logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Textbook whole-array expansion W[0..63]
  task automatic expand(input blk_t m, output sched_t w);
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++) w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
  endtask

  // Bus encoding of a word that should land in the window as x
  function automatic logic [31:0] to_bus(input logic [31:0] x);
`ifdef SCHED_BYTESWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic rand_blk(output blk_t m);
    for (int i = 0; i < 16; i++) m[i] = $urandom;
  endtask

  // Feed words start..15; returns at the negedge after the 16th accept
  task automatic load_block(input blk_t m, input bit gaps, input int start);
    for (int i = start; i < 16; i++) begin
      if (gaps) begin
        @(negedge clk);
        chk("load_gap_ready", 32'(out_word_ready), 32'd1);
        chk("load_gap_valid", 32'(out_valid), 32'd0);
        chk("load_gap_done", 32'(out_done), 32'd0);
        in_word_valid = 1'b0;
        in_word       = $urandom;
        in_advance    = 1'($urandom);
      end
      @(negedge clk);
      chk("load_ready", 32'(out_word_ready), 32'd1);
      chk("load_valid", 32'(out_valid), 32'd0);
      chk("load_done", 32'(out_done), 32'd0);
      in_word_valid = 1'b1;
      in_word       = to_bus(m[i]);
      in_advance    = 1'($urandom);
    end
    @(negedge clk);
    in_word_valid = 1'b0;
    in_word       = $urandom;
    in_advance    = 1'b0;
    chk("load_to_valid", 32'(out_valid), 32'd1);
    chk("run_ready", 32'(out_word_ready), 32'd0);
  endtask

  // Step through rounds, optionally stalling, stopping early, or chaining the next M0
  task automatic run_block(input blk_t m, input int stall_r, input int stall_n, input int stop_r,
                           input bit b2b, input logic [31:0] next_m0, input bit use_tab);
    sched_t w;
    expand(m, w);
    for (int r = 0; r < 64; r++) begin
      chk("run_valid", 32'(out_valid), 32'd1);
      chk("run_round", 32'(out_round), 32'(r));
      chk("run_wi", out_Wi, w[r]);
      chk("run_ki", out_Ki, K[r]);
      chk("run_done", 32'(out_done), 32'd0);
      if (use_tab) begin
        for (int j = 0; j < 5; j++) begin
          if (vtab[j].round == r) begin
            if (vtab[j].chk_wi) chk("vec_wi", out_Wi, vtab[j].wi);
            chk("vec_ki", out_Ki, vtab[j].ki);
          end
        end
      end
      if (r == stop_r) return;
      if (r == stall_r) begin
        in_advance = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          chk("stall_round", 32'(out_round), 32'(r));
          chk("stall_wi", out_Wi, w[r]);
          chk("stall_valid", 32'(out_valid), 32'd1);
        end
      end
      in_advance    = 1'b1;
      in_word_valid = 1'($urandom);
      in_word       = $urandom;
      @(negedge clk);
    end
    in_advance = 1'b0;
    chk("done_pulse", 32'(out_done), 32'd1);
    chk("done_valid", 32'(out_valid), 32'd0);
    chk("done_ready", 32'(out_word_ready), 32'd1);
    chk("done_round", 32'(out_round), 32'd0);
    if (b2b) begin
      in_word_valid = 1'b1;
      in_word       = to_bus(next_m0);
    end else begin
      in_word_valid = 1'b0;
      @(negedge clk);
      chk("done_once", 32'(out_done), 32'd0);
      chk("idle_valid", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    blk_t abc, b1, b2, b3;

    vtab[0] = '{round: 0,  wi: 32'h61626380, ki: 32'h428a2f98, chk_wi: 1'b1};
    vtab[1] = '{round: 15, wi: 32'h00000018, ki: 32'hc19bf174, chk_wi: 1'b1};
    vtab[2] = '{round: 16, wi: 32'h61626380, ki: 32'he49b69c1, chk_wi: 1'b1};
    vtab[3] = '{round: 17, wi: 32'h000f0000, ki: 32'hefbe4786, chk_wi: 1'b1};
    vtab[4] = '{round: 63, wi: 32'h00000000, ki: 32'hc67178f2, chk_wi: 1'b0};

    for (int i = 0; i < 16; i++) abc[i] = 32'h0;
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;

    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(out_word_ready), 32'd1);
    chk("rst_round", 32'(out_round), 32'd0);
    chk("rst_wi", out_Wi, 32'd0);
    chk("rst_done", 32'(out_done), 32'd0);
    chk("rst_ki", out_Ki, 32'h428a2f98);
    @(negedge clk);
    rst_n = 1'b1;

    // "abc" block at full rate
    load_block(abc, 1'b0, 0);
    run_block(abc, -1, 0, 99, 1'b0, 32'h0, 1'b1);

    // Stall at round 17, then chain a gapped block starting in the done cycle
    rand_blk(b1);
    load_block(abc, 1'b0, 0);
    run_block(abc, 17, 5, 99, 1'b1, b1[0], 1'b1);
    load_block(b1, 1'b1, 1);
    run_block(b1, int'($urandom_range(0, 63)), int'($urandom_range(1, 4)), 99, 1'b0, 32'h0, 1'b0);

    // Reset mid-run at round 20
    rand_blk(b2);
    load_block(b2, 1'b0, 0);
    run_block(b2, -1, 0, 20, 1'b0, 32'h0, 1'b0);
    in_advance    = 1'b0;
    in_word_valid = 1'b0;
    rst_n         = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_round", 32'(out_round), 32'd0);
    chk("midrst_ready", 32'(out_word_ready), 32'd1);
    chk("midrst_wi", out_Wi, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_valid", 32'(out_valid), 32'd0);
    load_block(abc, 1'b1, 0);
    run_block(abc, -1, 0, 99, 1'b0, 32'h0, 1'b1);

    // Randomised blocks with random gaps and stalls
    for (int k = 0; k < 4; k++) begin
      rand_blk(b3);
      load_block(b3, 1'($urandom), 0);
      run_block(b3, int'($urandom_range(0, 63)), int'($urandom_range(1, 4)), 99, 1'b0, 32'h0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
